// File: rtl/if_stage_btb.sv
// if_stage_btb: fetch stage with a direct-mapped BTB, 2-bit direction counters and IF/ID registers
module if_stage_btb #(
    parameter logic [31:0] RESET_PC    = 32'h4000_0000,
    parameter int          BTB_ENTRIES = 16,
    parameter logic [3:0]  BIOS_PREFIX = 4'h4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_stall,
    input  logic        ex_stall,
    input  logic        ex_redirect,
    input  logic [31:0] ex_redirect_pc,
    input  logic        ex_update_en,
    input  logic [31:0] ex_update_pc,
    input  logic        ex_update_taken,
    input  logic [31:0] ex_update_target,
    output logic [31:0] if_addr,
    output logic        if_bios_en,
    output logic [31:0] id_pc,
    output logic        id_valid,
    output logic        id_pred_taken,
    output logic [31:0] id_pred_target
);
    localparam int IDX = $clog2(BTB_ENTRIES);
    localparam int TW  = 30 - IDX;
    logic [31:0]                  pc_q, next_pc;
    logic [BTB_ENTRIES-1:0]       valid;
    logic [BTB_ENTRIES-1:0][1:0]  ctr;
    logic [TW-1:0]                tag_mem [BTB_ENTRIES];
    logic [31:0]                  tgt [BTB_ENTRIES];
    logic [IDX-1:0]               idx, uidx;
    logic                         hit, pred_taken, uhit, stall;
    logic [1:0]                   ctr_u, ctr_nxt;
    logic                         unused;
    assign unused     = ^ex_update_pc[1:0];
    assign stall      = id_stall | ex_stall;
    assign if_bios_en = if_addr[31:28] == BIOS_PREFIX;
    always_comb begin
        if_addr    = ex_redirect ? ex_redirect_pc : pc_q;
        idx        = if_addr[IDX+1:2];
        hit        = valid[idx] & (tag_mem[idx] == if_addr[31:IDX+2]);
        pred_taken = hit & ctr[idx][1];
        next_pc    = pred_taken ? tgt[idx] : if_addr + 32'd4;
        uidx       = ex_update_pc[IDX+1:2];
        uhit       = valid[uidx] & (tag_mem[uidx] == ex_update_pc[31:IDX+2]);
        ctr_u      = ctr[uidx];
        // a miss only reaches the counter on a taken allocation, which starts weakly taken
        ctr_nxt    = !uhit ? 2'b10 :
                     ex_update_taken ? (ctr_u == 2'b11 ? ctr_u : ctr_u + 2'd1) :
                     (ctr_u == 2'b00 ? ctr_u : ctr_u - 2'd1);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q           <= RESET_PC;
            id_pc          <= '0;
            id_valid       <= 1'b0;
            id_pred_taken  <= 1'b0;
            id_pred_target <= '0;
            valid          <= '0;
            ctr            <= {BTB_ENTRIES{2'b01}};
        end else begin
            if (!stall) begin
                pc_q           <= next_pc;
                id_pc          <= if_addr;
                id_valid       <= 1'b1;
                id_pred_taken  <= pred_taken;
                id_pred_target <= pred_taken ? tgt[idx] : '0;
            end else if (ex_redirect) begin
                pc_q     <= ex_redirect_pc;
                id_valid <= 1'b0;
            end
            if (ex_update_en && (uhit || ex_update_taken))
                ctr[uidx] <= ctr_nxt;
            if (ex_update_en && ex_update_taken)
                valid[uidx] <= 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst && ex_update_en && ex_update_taken) begin
            tag_mem[uidx] <= ex_update_pc[31:IDX+2];
            tgt[uidx]     <= ex_update_target;
        end
    end
endmodule

// File: tb/tb_if_stage_btb.sv
// tb_if_stage_btb: directed vector table, corner sequences and random traffic against a BTB model
module tb_if_stage_btb;
    localparam int N  = 16;
    localparam int IW = 4;
    logic        clk = 1'b0;
    logic        rst, id_stall, ex_stall, ex_redirect, ex_update_en, ex_update_taken;
    logic [31:0] ex_redirect_pc, ex_update_pc, ex_update_target;
    logic [31:0] if_addr, id_pc, id_pred_target;
    logic        if_bios_en, id_valid, id_pred_taken;
    int checks = 0;
    int failures = 0;
    logic [31:0] s_addr;
    // behavioural model state
    logic [31:0] m_pc, m_id_pc, m_ptgt;
    bit          m_idv, m_pt;
    bit          m_v [N];
    logic [31:0] m_tag [N];
    logic [31:0] m_tgt [N];
    int          m_c [N];

    if_stage_btb dut (
        .clk(clk), .rst(rst), .id_stall(id_stall), .ex_stall(ex_stall),
        .ex_redirect(ex_redirect), .ex_redirect_pc(ex_redirect_pc),
        .ex_update_en(ex_update_en), .ex_update_pc(ex_update_pc),
        .ex_update_taken(ex_update_taken), .ex_update_target(ex_update_target),
        .if_addr(if_addr), .if_bios_en(if_bios_en), .id_pc(id_pc), .id_valid(id_valid),
        .id_pred_taken(id_pred_taken), .id_pred_target(id_pred_target)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", n, a, e);
        end
    endtask

    function automatic int m_idx(input logic [31:0] a);
        return int'((a >> 2) % N);
    endfunction

    function automatic logic [31:0] m_tg(input logic [31:0] a);
        return a >> (2 + IW);
    endfunction

    task automatic m_reset();
        m_pc = 32'h4000_0000; m_id_pc = 0; m_idv = 0; m_pt = 0; m_ptgt = 0;
        for (int i = 0; i < N; i++) begin m_v[i] = 0; m_c[i] = 1; end
    endtask

    // one cycle: drive at negedge, check fetch side, clock, advance model, check IF/ID side
    task automatic step(input bit r, input bit st, input bit es, input bit rd, input logic [31:0] rpc,
                        input bit ue, input logic [31:0] upc, input bit ut, input logic [31:0] utg);
        logic [31:0] fa;
        int i, j;
        bit p, uh;
        rst = r; id_stall = st; ex_stall = es; ex_redirect = rd; ex_redirect_pc = rpc;
        ex_update_en = ue; ex_update_pc = upc; ex_update_taken = ut; ex_update_target = utg;
        #1;
        fa = rd ? rpc : m_pc;
        i  = m_idx(fa);
        p  = m_v[i] && m_tag[i] == m_tg(fa) && m_c[i] >= 2;
        s_addr = if_addr;
        if (!r) begin
            chk("if_addr", if_addr, fa);
            chk("if_bios_en", 32'(if_bios_en), 32'(fa[31:28] == 4'h4));
        end
        @(posedge clk);
        if (r) m_reset();
        else begin
            if (!(st || es)) begin
                m_pc = p ? m_tgt[i] : fa + 32'd4;
                m_id_pc = fa; m_idv = 1; m_pt = p; m_ptgt = p ? m_tgt[i] : 0;
            end else if (rd) begin
                m_pc = rpc; m_idv = 0;
            end
            j  = m_idx(upc);
            uh = m_v[j] && m_tag[j] == m_tg(upc);
            if (ue && uh) begin
                m_c[j] = ut ? (m_c[j] < 3 ? m_c[j] + 1 : 3) : (m_c[j] > 0 ? m_c[j] - 1 : 0);
                if (ut) m_tgt[j] = utg;
            end else if (ue && ut) begin
                m_v[j] = 1; m_tag[j] = m_tg(upc); m_tgt[j] = utg; m_c[j] = 2;
            end
        end
        @(negedge clk);
        chk("id_pc", id_pc, m_id_pc);
        chk("id_valid", 32'(id_valid), 32'(m_idv));
        chk("id_pred_taken", 32'(id_pred_taken), 32'(m_pt));
        chk("id_pred_target", id_pred_target, m_ptgt);
    endtask

    typedef struct {
        bit st, es, rd; logic [31:0] rpc;
        bit ue; logic [31:0] upc; bit ut; logic [31:0] utg;
        logic [31:0] e_addr, e_idpc; bit e_v, e_pt;
    } vec_t;

    function automatic vec_t mk(input bit st, input bit es, input bit rd, input logic [31:0] rpc,
                                input bit ue, input logic [31:0] upc, input bit ut, input logic [31:0] utg,
                                input logic [31:0] ea, input logic [31:0] ep, input bit ev, input bit et);
        vec_t v;
        v.st = st; v.es = es; v.rd = rd; v.rpc = rpc; v.ue = ue; v.upc = upc; v.ut = ut; v.utg = utg;
        v.e_addr = ea; v.e_idpc = ep; v.e_v = ev; v.e_pt = et;
        return v;
    endfunction

    vec_t tbl [33];
    logic [31:0] pool [8];

    initial begin
        pool = '{32'h1000_0010, 32'h1000_0050, 32'h1000_0090, 32'h1000_0014,
                 32'h4000_0000, 32'h4000_000C, 32'hFFFF_FFFC, 32'h1000_0100};
        tbl[0]  = mk(0,0,0,0,            0,0,0,0,                          32'h4000_0000,32'h4000_0000,1,0);
        tbl[1]  = mk(0,0,0,0,            0,0,0,0,                          32'h4000_0004,32'h4000_0004,1,0);
        tbl[2]  = mk(1,0,0,0,            0,0,0,0,                          32'h4000_0008,32'h4000_0004,1,0);
        tbl[3]  = mk(1,0,0,0,            0,0,0,0,                          32'h4000_0008,32'h4000_0004,1,0);
        tbl[4]  = mk(1,0,0,0,            0,0,0,0,                          32'h4000_0008,32'h4000_0004,1,0);
        tbl[5]  = mk(0,0,0,0,            0,0,0,0,                          32'h4000_0008,32'h4000_0008,1,0);
        tbl[6]  = mk(0,0,0,0,            0,0,0,0,                          32'h4000_000C,32'h4000_000C,1,0);
        tbl[7]  = mk(0,0,1,32'h1000_0000,0,0,0,0,                          32'h1000_0000,32'h1000_0000,1,0);
        tbl[8]  = mk(0,0,0,0,            0,0,0,0,                          32'h1000_0004,32'h1000_0004,1,0);
        tbl[9]  = mk(0,1,1,32'h1000_0000,0,0,0,0,                          32'h1000_0000,32'h1000_0004,0,0);
        tbl[10] = mk(0,0,0,0,            0,0,0,0,                          32'h1000_0000,32'h1000_0000,1,0);
        tbl[11] = mk(0,0,0,0,            1,32'h1000_0010,1,32'h1000_0100,  32'h1000_0004,32'h1000_0004,1,0);
        tbl[12] = mk(0,0,0,0,            0,0,0,0,                          32'h1000_0008,32'h1000_0008,1,0);
        tbl[13] = mk(0,0,0,0,            0,0,0,0,                          32'h1000_000C,32'h1000_000C,1,0);
        tbl[14] = mk(0,0,0,0,            0,0,0,0,                          32'h1000_0010,32'h1000_0010,1,1);
        tbl[15] = mk(0,0,0,0,            1,32'h1000_0010,0,0,              32'h1000_0100,32'h1000_0100,1,0);
        tbl[16] = mk(0,0,0,0,            1,32'h1000_0010,0,0,              32'h1000_0104,32'h1000_0104,1,0);
        tbl[17] = mk(0,0,1,32'h1000_0010,0,0,0,0,                          32'h1000_0010,32'h1000_0010,1,0);
        tbl[18] = mk(0,0,0,0,            1,32'h1000_0010,1,32'h1000_0100,  32'h1000_0014,32'h1000_0014,1,0);
        tbl[19] = mk(0,0,0,0,            1,32'h1000_0010,1,32'h1000_0100,  32'h1000_0018,32'h1000_0018,1,0);
        tbl[20] = mk(0,0,0,0,            1,32'h1000_0010,1,32'h1000_0100,  32'h1000_001C,32'h1000_001C,1,0);
        tbl[21] = mk(0,0,0,0,            1,32'h1000_0010,1,32'h1000_0100,  32'h1000_0020,32'h1000_0020,1,0);
        tbl[22] = mk(0,0,0,0,            1,32'h1000_0010,0,0,              32'h1000_0024,32'h1000_0024,1,0);
        tbl[23] = mk(0,0,1,32'h1000_0010,0,0,0,0,                          32'h1000_0010,32'h1000_0010,1,1);
        tbl[24] = mk(0,0,0,0,            1,32'h1000_0050,1,32'h1000_0200,  32'h1000_0100,32'h1000_0100,1,0);
        tbl[25] = mk(0,0,1,32'h1000_0010,0,0,0,0,                          32'h1000_0010,32'h1000_0010,1,0);
        tbl[26] = mk(0,0,0,0,            1,32'h1000_0090,0,0,              32'h1000_0014,32'h1000_0014,1,0);
        tbl[27] = mk(0,0,1,32'h1000_0050,0,0,0,0,                          32'h1000_0050,32'h1000_0050,1,1);
        tbl[28] = mk(0,0,1,32'h1000_0050,1,32'h1000_0050,0,0,              32'h1000_0050,32'h1000_0050,1,1);
        tbl[29] = mk(0,0,1,32'h1000_0050,0,0,0,0,                          32'h1000_0050,32'h1000_0050,1,0);
        tbl[30] = mk(0,0,0,0,            0,0,0,0,                          32'h1000_0054,32'h1000_0054,1,0);
        tbl[31] = mk(0,0,1,32'hFFFF_FFFC,0,0,0,0,                          32'hFFFF_FFFC,32'hFFFF_FFFC,1,0);
        tbl[32] = mk(0,0,0,0,            0,0,0,0,                          32'h0000_0000,32'h0000_0000,1,0);

        @(negedge clk);
        step(1,0,0,0,0,0,0,0,0);
        step(1,0,0,0,0,0,0,0,0);
        chk("rst_id_pc", id_pc, 32'h0);
        chk("rst_id_valid", 32'(id_valid), 32'h0);
        chk("rst_pred", 32'(id_pred_taken), 32'h0);
        chk("rst_pred_target", id_pred_target, 32'h0);
        chk("rst_if_addr", if_addr, 32'h4000_0000);
        chk("rst_bios", 32'(if_bios_en), 32'h1);

        foreach (tbl[k]) begin
            step(0, tbl[k].st, tbl[k].es, tbl[k].rd, tbl[k].rpc,
                 tbl[k].ue, tbl[k].upc, tbl[k].ut, tbl[k].utg);
            chk($sformatf("tbl%0d_addr", k), s_addr, tbl[k].e_addr);
            chk($sformatf("tbl%0d_idpc", k), id_pc, tbl[k].e_idpc);
            chk($sformatf("tbl%0d_valid", k), 32'(id_valid), 32'(tbl[k].e_v));
            chk($sformatf("tbl%0d_pred", k), 32'(id_pred_taken), 32'(tbl[k].e_pt));
        end

        // reset asserted mid-stall must restore RESET_PC and forget trained entries
        step(0,0,0,0,0,1,32'h1000_0010,1,32'h1000_0100);
        step(0,1,0,0,0,0,0,0,0);
        step(1,1,0,0,0,0,0,0,0);
        chk("midrst_valid", 32'(id_valid), 32'h0);
        step(0,0,0,0,0,0,0,0,0);
        chk("midrst_addr", s_addr, 32'h4000_0000);
        step(0,0,0,1,32'h1000_0010,0,0,0,0);
        chk("midrst_nohit", 32'(id_pred_taken), 32'h0);
        step(0,0,0,0,0,0,0,0,0);
        chk("midrst_fallthru", s_addr, 32'h1000_0014);

        for (int n = 0; n < 400; n++)
            step($urandom_range(99) == 0, $urandom_range(4) == 0, $urandom_range(6) == 0,
                 $urandom_range(3) == 0, pool[$urandom_range(7)],
                 $urandom_range(1) == 1, pool[$urandom_range(7)], $urandom_range(2) != 0,
                 pool[$urandom_range(7)]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/if_stage_btb.md
Name: if_stage_btb

Overview:
- Next-generation instruction-fetch stage with a parametrised direct-mapped branch target buffer (BTB) and 2-bit saturating direction counters.
- Produces the fetch address and IF/ID pipeline registers: PC, prediction and valid bit.
- Accepts same-cycle redirects from EX on mispredict and BTB training updates from EX on resolved control transfers.
- Sits between the instruction memory / BIOS address mux and the ID stage.

Parameters:
- RESET_PC, 32'h4000_0000, PC value after reset.
- BTB_ENTRIES, 16, number of BTB entries; power of 2, minimum 2. IDX = log2(BTB_ENTRIES).
- BIOS_PREFIX, 4'h4, value of if_addr[31:28] that selects BIOS memory.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- id_stall  in  1  ID stall; holds PC and IF/ID registers.
- ex_stall  in  1  EX stall; same effect as id_stall.
- ex_redirect  in  1  EX mispredict; overrides the fetch address this cycle.
- ex_redirect_pc  in  32  correct PC for the redirect.
- ex_update_en  in  1  BTB training strobe.
- ex_update_pc  in  32  PC of the resolved branch or jump.
- ex_update_taken  in  1  resolved direction.
- ex_update_target  in  32  resolved target.
- if_addr  out  32  instruction fetch address (combinational).
- if_bios_en  out  1  if_addr[31:28] == BIOS_PREFIX.
- id_pc  out  32  PC of the instruction in ID.
- id_valid  out  1  ID instruction is not squashed.
- id_pred_taken  out  1  fetch-time prediction for id_pc.
- id_pred_target  out  32  predicted target; 0 when not taken.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high on `rst`.
- Reset values:
  - pc_q = RESET_PC.
  - id_pc = 0, id_valid = 0, id_pred_taken = 0, id_pred_target = 0.
  - All BTB valid bits = 0, all counters = 2'b01.
  - Reset overrides every other input.
- Fetch address: if_addr = ex_redirect ? ex_redirect_pc : pc_q. This is combinational, with zero-cycle redirect.
- Lookup on if_addr:
  - idx = if_addr[IDX+1:2]; tag = if_addr[31:IDX+2].
  - hit = valid[idx] & (tag_mem[idx] == tag).
  - pred_taken = hit & ctr[idx][1].
  - next_pc = pred_taken ? tgt[idx] : if_addr + 4, with 32-bit wraparound (32'hFFFF_FFFC + 4 = 0).
- stall = id_stall | ex_stall.
- PC update, per cycle:
  - !stall: pc_q <= next_pc.
  - stall & ex_redirect: pc_q <= ex_redirect_pc, so the redirect is not lost.
  - stall & !ex_redirect: pc_q holds.
- IF/ID registers:
  - !stall: id_pc <= if_addr, id_valid <= 1, id_pred_taken <= pred_taken, id_pred_target <= pred_taken ? tgt[idx] : 0.
  - stall & ex_redirect: id_valid <= 0; other ID registers hold.
  - stall & !ex_redirect: all ID registers hold.
- BTB update when ex_update_en (applied at the clock edge, independent of stall), using the idx/tag of ex_update_pc:
  - Hit and taken: ctr <= sat_inc(ctr), tgt <= ex_update_target.
  - Hit and not taken: ctr <= sat_dec(ctr).
  - Miss and taken: allocate or replace; valid <= 1, tag written, tgt <= ex_update_target, ctr <= 2'b10.
  - Miss and not taken: no change.
- Counter saturation: 2'b11 stays 2'b11 on taken; 2'b00 stays 2'b00 on not-taken.
- Same-cycle update and lookup to the same index: the lookup sees pre-update contents (read-old).
- Storage: the BTB is registers only; no reset-time initialisation loop.

Test Plan:
- Reset, then release with no stalls:
  - if_addr = 0x4000_0000, 0x4000_0004, 0x4000_0008 on successive cycles.
  - id_valid = 0 in the first cycle, then 1.
  - id_pc lags if_addr by 1 cycle.
  - if_bios_en = 1.
- Hold id_stall = 1 for 3 cycles at if_addr 0x4000_0008:
  - if_addr, id_pc and id_valid frozen.
  - Sequence resumes at 0x4000_000C after release.
- ex_redirect = 1 with ex_redirect_pc = 0x1000_0000:
  - Same cycle: if_addr = 0x1000_0000, if_bios_en = 0.
  - Next cycle: id_pc = 0x1000_0000; following if_addr = 0x1000_0004.
  - Repeat under ex_stall = 1: id_valid drops to 0, pc_q = 0x1000_0000 after release.
- Train: ex_update_en with pc = 0x1000_0010, taken, target = 0x1000_0100:
  - Next fetch of 0x1000_0010 gives id_pred_taken = 1 and following if_addr = 0x1000_0100.
  - Two not-taken updates drop ctr 10 -> 01 -> 00; prediction becomes not taken (next if_addr = 0x1000_0014).
- Aliasing, with BTB_ENTRIES = 16:
  - A taken update at 0x1000_0050 (same idx as 0x1000_0010) replaces the entry.
  - A fetch of 0x1000_0010 then misses (fall-through +4).
  - A not-taken update to an unallocated PC leaves the BTB unchanged.
- Corner cases:
  - Saturation: 4 taken updates leave ctr = 11; 1 not-taken update then still predicts taken.
  - Update and fetch of the same PC in one cycle: old prediction used.
  - rst asserted mid-stall restores RESET_PC and clears all BTB hits.
